// File: rtl/prach_hb1_pack.sv
`default_nettype none
// ============================================================================
//  Module   : prach_hb1_pack
//  Purpose  : Even/odd polyphase pair packer for a TDM multi-channel stream.
//             Buffers each channel's even-phase sample and emits it together
//             with the matching odd-phase sample as one (dp1, dp2) pair, in
//             the format the stage-1 half-band decimator consumes.
//             sync_in restarts the phase of every channel.
//  Revision : 1.0  - initial release
// ============================================================================
module prach_hb1_pack #(
    parameter int NUM_CH = 8,
    parameter int LANES  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din_d [LANES],
    input  logic        din_dv,
    input  logic [7:0]  din_chn,
    input  logic        sync_in,
    output logic [15:0] dout_dp1 [LANES],
    output logic [15:0] dout_dp2 [LANES],
    output logic        dout_dv,
    output logic [7:0]  dout_chn,
    output logic        sync_out,
    output logic        err_chn
);

    // Channel index width; storage is rounded up to a power of two so that
    // the index can never address outside the arrays. Entries at or above
    // NUM_CH are never written because such samples are rejected.
    localparam int         CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int         DEPTH    = 1 << CHW;
    localparam logic [8:0] NUM_CH_W = 9'(NUM_CH);

    // Per-channel state
    logic [DEPTH-1:0] phase_q, phase_d;
    logic [15:0]      even_q [DEPTH][LANES];
    logic             sync_pend_q, sync_pend_d;

    // Registered outputs
    logic [15:0] dout_dp1_q [LANES];
    logic [15:0] dout_dp2_q [LANES];
    logic        dout_dv_q;
    logic [7:0]  dout_chn_q;
    logic        sync_out_q;
    logic        err_chn_q;

    logic [CHW-1:0] w_idx;
    logic           w_chn_ok;
    logic           w_acc;
    logic           w_phase_cur;
    logic           w_even_wr;
    logic           w_pair;

    assign w_idx    = din_chn[CHW-1:0];
    assign w_chn_ok = ({1'b0, din_chn} < NUM_CH_W);
    assign w_acc    = din_dv & w_chn_ok;
    // A sync clears every phase before the same-cycle sample is looked at,
    // so a sample arriving together with sync is always treated as even.
    assign w_phase_cur = sync_in ? 1'b0 : phase_q[w_idx];
    assign w_even_wr   = w_acc & ~w_phase_cur;
    assign w_pair      = w_acc &  w_phase_cur;

    // Next-state for the phase bits and the pending-sync flag
    always_comb begin
        phase_d     = sync_in ? '0 : phase_q;
        sync_pend_d = sync_pend_q;
        if (w_acc) begin
            phase_d[w_idx] = ~w_phase_cur;
        end
        if (sync_in) begin
            sync_pend_d = 1'b1;
        end else if (w_pair) begin
            sync_pend_d = 1'b0;
        end
    end

    // Phase and sync-pending state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            sync_pend_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            sync_pend_q <= sync_pend_d;
        end
    end

    // Even-sample buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_even_wr) begin
            even_q[w_idx] <= din_d;
        end
    end

    // Output pair registers: pulse dv for one cycle, hold data otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                dout_dp1_q[k] <= '0;
                dout_dp2_q[k] <= '0;
            end
            dout_dv_q  <= 1'b0;
            dout_chn_q <= '0;
            sync_out_q <= 1'b0;
        end else begin
            dout_dv_q  <= w_pair;
            sync_out_q <= w_pair & sync_pend_q;
            if (w_pair) begin
                dout_dp1_q <= even_q[w_idx];
                dout_dp2_q <= din_d;
                dout_chn_q <= din_chn;
            end
        end
    end

    // Sticky out-of-range channel flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_chn_q <= 1'b0;
        end else if (din_dv && !w_chn_ok) begin
            err_chn_q <= 1'b1;
        end
    end

    assign dout_dp1 = dout_dp1_q;
    assign dout_dp2 = dout_dp2_q;
    assign dout_dv  = dout_dv_q;
    assign dout_chn = dout_chn_q;
    assign sync_out = sync_out_q;
    assign err_chn  = err_chn_q;

endmodule
`default_nettype wire

// File: tb/tb_prach_hb1_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prach_hb1_pack
//  Purpose  : Self-checking bench for prach_hb1_pack. Two instances share one
//             stimulus stream: NUM_CH=8 and NUM_CH=1.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_prach_hb1_pack;

    localparam int LANES = 3;
    localparam int NM    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din_d [LANES];
    logic        din_dv;
    logic [7:0]  din_chn;
    logic        sync_in;

    logic [15:0] dp1 [NM][LANES];
    logic [15:0] dp2 [NM][LANES];
    logic        dv  [NM];
    logic [7:0]  chn [NM];
    logic        so  [NM];
    logic        err [NM];

    int checks   = 0;
    int failures = 0;
    bit running  = 1'b1;

    always #5 clk = ~clk;

    prach_hb1_pack #(.NUM_CH(8), .LANES(LANES)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .din_d(din_d), .din_dv(din_dv),
        .din_chn(din_chn), .sync_in(sync_in),
        .dout_dp1(dp1[0]), .dout_dp2(dp2[0]), .dout_dv(dv[0]),
        .dout_chn(chn[0]), .sync_out(so[0]), .err_chn(err[0])
    );

    prach_hb1_pack #(.NUM_CH(1), .LANES(LANES)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din_d(din_d), .din_dv(din_dv),
        .din_chn(din_chn), .sync_in(sync_in),
        .dout_dp1(dp1[1]), .dout_dp2(dp2[1]), .dout_dv(dv[1]),
        .dout_chn(chn[1]), .sync_out(so[1]), .err_chn(err[1])
    );

    // ------------------------------------------------------------------
    // Behavioural model: per channel, "is there an unpaired even sample
    // waiting, and what was it". A pair is produced when a second sample
    // of the same channel arrives.
    // ------------------------------------------------------------------
    int          nch [NM] = '{8, 1};
    bit          have_even [NM][256];
    logic [15:0] even_val  [NM][256][LANES];
    bit          pend      [NM];
    logic [15:0] e_dp1 [NM][LANES];
    logic [15:0] e_dp2 [NM][LANES];
    bit          e_dv  [NM];
    logic [7:0]  e_chn [NM];
    bit          e_so  [NM];
    bit          e_err [NM];

    task automatic model_reset();
        for (int m = 0; m < NM; m++) begin
            for (int c = 0; c < 256; c++) have_even[m][c] = 1'b0;
            pend[m]  = 1'b0;
            e_dv[m]  = 1'b0;
            e_so[m]  = 1'b0;
            e_err[m] = 1'b0;
            e_chn[m] = 8'd0;
            for (int k = 0; k < LANES; k++) begin
                e_dp1[m][k] = 16'd0;
                e_dp2[m][k] = 16'd0;
            end
        end
    endtask

    // Evaluate one clock edge of the model using the current inputs.
    task automatic model_edge();
        for (int m = 0; m < NM; m++) begin
            e_dv[m] = 1'b0;
            e_so[m] = 1'b0;
            if (sync_in) begin
                for (int c = 0; c < 256; c++) have_even[m][c] = 1'b0;
                pend[m] = 1'b1;
            end
            if (din_dv && int'(din_chn) >= nch[m]) e_err[m] = 1'b1;
            if (din_dv && int'(din_chn) < nch[m]) begin
                if (!have_even[m][din_chn]) begin
                    have_even[m][din_chn] = 1'b1;
                    for (int k = 0; k < LANES; k++) even_val[m][din_chn][k] = din_d[k];
                end else begin
                    have_even[m][din_chn] = 1'b0;
                    e_dv[m]  = 1'b1;
                    e_so[m]  = pend[m];
                    pend[m]  = 1'b0;
                    e_chn[m] = din_chn;
                    for (int k = 0; k < LANES; k++) begin
                        e_dp1[m][k] = even_val[m][din_chn][k];
                        e_dp2[m][k] = din_d[k];
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Compare every instance's outputs to the model on each falling edge.
    initial begin
        while (running) begin
            @(negedge clk);
            if (running) begin
                for (int m = 0; m < NM; m++) begin
                    chk($sformatf("m%0d_dv", m),  32'(dv[m]),  32'(e_dv[m]));
                    chk($sformatf("m%0d_so", m),  32'(so[m]),  32'(e_so[m]));
                    chk($sformatf("m%0d_err", m), 32'(err[m]), 32'(e_err[m]));
                    chk($sformatf("m%0d_chn", m), 32'(chn[m]), 32'(e_chn[m]));
                    for (int k = 0; k < LANES; k++) begin
                        chk($sformatf("m%0d_dp1_%0d", m, k), 32'(dp1[m][k]), 32'(e_dp1[m][k]));
                        chk($sformatf("m%0d_dp2_%0d", m, k), 32'(dp2[m][k]), 32'(e_dp2[m][k]));
                    end
                end
            end
        end
    end

    // Apply one input cycle; returns 1 time unit after the edge.
    task automatic step(input bit dv_i, input logic [7:0] ch_i,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input bit sy_i);
        din_dv  = dv_i;
        din_chn = ch_i;
        din_d[0] = d0;
        din_d[1] = d1;
        din_d[2] = d2;
        sync_in = sy_i;
        @(posedge clk);
        model_edge();
        #1;
        din_dv  = 1'b0;
        sync_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        din_dv  = 1'b0;
        sync_in = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] pat(input int c, input int r, input int k);
        return {8'(c), 4'(r), 4'(k)};
    endfunction

    initial begin
        rst_n   = 1'b1;
        din_dv  = 1'b0;
        din_chn = 8'd0;
        sync_in = 1'b0;
        for (int k = 0; k < LANES; k++) din_d[k] = 16'd0;
        #2;
        do_reset(3);
        chk("rst_dv", 32'(dv[0]), 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        chk("rst_dp1", 32'(dp1[0][2]), 32'd0);

        // Two round-robin rounds on channels 0..7
        for (int r = 1; r <= 2; r++) begin
            for (int c = 0; c < 8; c++) begin
                step(1'b1, 8'(c), pat(c, r, 0), pat(c, r, 1), pat(c, r, 2), 1'b0);
                if (r == 2 && c == 0) begin
                    chk("rr_ch0_dv",  32'(dv[0]), 32'd1);
                    chk("rr_ch0_dp1", 32'(dp1[0][1]), 32'h0011);
                    chk("rr_ch0_dp2", 32'(dp2[0][1]), 32'h0021);
                end
            end
        end
        chk("rr_ch7_chn", 32'(chn[0]), 32'd7);
        chk("rr_ch7_dp2", 32'(dp2[0][2]), 32'h0722);
        chk("rr_err", 32'(err[0]), 32'd0);
        idle(2);

        // Sync coinciding with the first ch0 sample, then the rest of 16
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i % 8), pat(i % 8, 3 + i / 8, 0), pat(i % 8, 3 + i / 8, 1),
                 pat(i % 8, 3 + i / 8, 2), i == 0);
            if (i == 8)  chk("sync_first_so", 32'(so[0]), 32'd1);
            if (i == 9)  chk("sync_second_so", 32'(so[0]), 32'd0);
        end
        idle(2);

        // Partial pair discarded by sync
        step(1'b1, 8'd3, 16'hDEAD, 16'hDEAD, 16'hDEAD, 1'b0);
        step(1'b0, 8'd0, 16'd0, 16'd0, 16'd0, 1'b1);
        step(1'b1, 8'd3, 16'hAAAA, 16'hA001, 16'hA002, 1'b0);
        chk("partial_nodv", 32'(dv[0]), 32'd0);
        step(1'b1, 8'd3, 16'hBBBB, 16'hB001, 16'hB002, 1'b0);
        chk("partial_dp1", 32'(dp1[0][0]), 32'hAAAA);
        chk("partial_dp2", 32'(dp2[0][0]), 32'hBBBB);
        chk("partial_so",  32'(so[0]), 32'd1);
        idle(2);

        // Invalid channel mid-stream
        step(1'b1, 8'd1, 16'h1111, 16'h1112, 16'h1113, 1'b0);
        step(1'b1, 8'd9, 16'h9999, 16'h9999, 16'h9999, 1'b0);
        chk("badch_err", 32'(err[0]), 32'd1);
        chk("badch_nodv", 32'(dv[0]), 32'd0);
        step(1'b1, 8'd1, 16'h2221, 16'h2222, 16'h2223, 1'b0);
        chk("badch_pair_dp1", 32'(dp1[0][0]), 32'h1111);
        chk("badch_pair_dp2", 32'(dp2[0][2]), 32'h2223);
        idle(3);
        chk("badch_sticky", 32'(err[0]), 32'd1);

        // Back-to-back on a single channel (NUM_CH=1 instance)
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'd0, 16'(i), 16'(i), 16'(i), 1'b0);
            if (i == 1) begin
                chk("n1_pair0_dp1", 32'(dp1[1][0]), 32'd0);
                chk("n1_pair0_dp2", 32'(dp2[1][0]), 32'd1);
            end
            if (i == 2) chk("n1_gap_dv", 32'(dv[1]), 32'd0);
            if (i == 3) begin
                chk("n1_pair1_dp1", 32'(dp1[1][1]), 32'd2);
                chk("n1_pair1_dp2", 32'(dp2[1][1]), 32'd3);
            end
        end
        chk("n1_err", 32'(err[1]), 32'd0);
        idle(2);

        // Reset between an even sample and its partner
        step(1'b1, 8'd0, 16'h5555, 16'h5555, 16'h5555, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("midrst_dp1", 32'(dp1[0][0]), 32'd0);
        chk("midrst_chn", 32'(chn[0]), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'd0, 16'h1234, 16'h1235, 16'h1236, 1'b0);
        chk("midrst_nodv", 32'(dv[0]), 32'd0);
        step(1'b1, 8'd0, 16'h5678, 16'h5679, 16'h567A, 1'b0);
        chk("midrst_dp1_x", 32'(dp1[0][0]), 32'h1234);
        chk("midrst_dp2_y", 32'(dp2[0][0]), 32'h5678);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] c;
            c = ($urandom_range(0, 29) == 0) ? 8'($urandom_range(8, 255))
                                             : 8'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, c, 16'($urandom), 16'($urandom),
                 16'($urandom), $urandom_range(0, 39) == 0);
        end
        idle(2);

        running = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prach_hb1_pack.md
Name: prach_hb1_pack

Overview:
- Upstream companion to the stage-1 half-band decimator.
- Takes a TDM multi-channel sample stream carrying three parallel 16-bit lanes and holds each channel's even-phase sample in a per-channel buffer.
- When the same channel's odd-phase sample arrives, it emits the even/odd pair as dp1/dp2. The output therefore runs at half the input sample rate per channel, in the exact polyphase format the half-band decimator consumes.
- It also owns phase alignment: sync_in restarts every channel's phase.

Parameters:
- NUM_CH, 8, number of TDM channels; valid din_chn range is 0..NUM_CH-1; legal range 1..256.
- LANES, 3, number of parallel 16-bit lanes; fixed at 3 for the PRACH path.

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous active-low reset
- din_d  input  16 x LANES  input sample per lane (unpacked array [LANES])
- din_dv  input  1  input sample valid
- din_chn  input  8  channel index of din_d
- sync_in  input  1  frame sync; restarts phase of all channels
- dout_dp1  output  16 x LANES  even-phase (older) sample per lane
- dout_dp2  output  16 x LANES  odd-phase (newer) sample per lane
- dout_dv  output  1  output pair valid, one-cycle pulse per pair
- dout_chn  output  8  channel index of the pair
- sync_out  output  1  marks the first pair emitted after a sync
- err_chn  output  1  sticky: a sample arrived with din_chn >= NUM_CH

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0.
  - phase[NUM_CH] goes to 0 and sync_pend goes to 0.
  - Buffer contents are don't-care; they are not reset.
- Per-channel state:
  - phase bit (0 = next sample is even, 1 = next sample is odd).
  - even buffer of LANES x 16 bits, held in a register array indexed by channel.
- Accepted sample: din_dv=1 and din_chn < NUM_CH.
  - If phase==0: write din_d to the even buffer[chn] and set phase=1. No output.
  - If phase==1: on the next cycle output dout_dp1=buffer[chn], dout_dp2=din_d (sampled on the accepting edge), dout_chn=chn, dout_dv=1. Clear phase to 0.
- Latency: exactly 1 clk from the accepting edge of the odd sample to dout_dv high. All outputs are registered.
- dout_dv is high for one cycle per pair.
  - dout_dp1/dp2/chn hold their last values while dout_dv=0.
  - No back-pressure exists. Downstream must accept every pulse.
- Throughput: one input per cycle, sustained. Back-to-back samples of the same channel are legal (NUM_CH=1 case): even at cycle t, odd at t+1, pair out at t+2.
- Invalid channel (din_dv=1, din_chn >= NUM_CH):
  - Sample dropped; no state changes.
  - err_chn set to 1 and held until reset.
- sync_in=1 (with or without din_dv):
  - All phase bits clear to 0 before the same-cycle sample is processed, so a sample coinciding with sync is treated as even.
  - sync_pend is set.
  - A repeated sync_in while pending restarts phases again and sync_pend stays set.
- sync_out:
  - Asserted together with dout_dv on the first pair emitted after sync_pend is set.
  - That pair's odd sample must arrive on a cycle without sync_in.
  - sync_pend clears on the same edge.
  - sync_out is 0 whenever dout_dv is 0.
- Partial pair: an even sample whose odd partner never arrives before sync is discarded silently; its buffer entry is overwritten later.
- Arithmetic: no arithmetic on data. Pure storage and routing, bit-exact; signed values pass unmodified.
- Mid-operation reset: in-flight evens are lost, and the first post-reset sample per channel is treated as even.

Test Plan:
- NUM_CH=8, channels 0..7 round-robin, two full rounds, din_d lane k = {chn, round, k} → 8 pairs at latency 1 after each round-2 sample; dp1 = round-1 value, dp2 = round-2 value, dout_chn 0..7 in order, no err_chn.
- sync_in with first sample of ch0, then 16 samples round-robin → sync_out=1 only on the ch0 pair (first output); all later pairs have sync_out=0.
- Feed ch3 even only, pulse sync_in, feed ch3 twice (A,B) → exactly one pair, dp1=A, dp2=B; the pre-sync sample never appears.
- din_chn=9 with NUM_CH=8 mid-stream → no dout_dv for it, err_chn rises the next cycle and stays 1; other channels' pairing is unaffected.
- NUM_CH=1, continuous din_dv with incrementing data 0,1,2,3 → pairs (0,1) and (2,3) with dout_dv every other cycle.
- Assert rst_n low after ch0 even sample, release, send ch0 X,Y → all outputs 0 during reset; output pair (X,Y).
